// File: rtl/csd_pkg.sv
// csd_pkg: shared types, zero-weight command and NAF digit helper for the CSD term encoder
package csd_pkg;
  localparam int CN = 4;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  typedef logic [1:0] digit_t;
  typedef struct packed {
    logic [CN-1:0] b_i;
    logic [CN-1:0] b_j;
    logic          one_term;
    logic          b_sign;
    logic          pair_neg;
    logic          zero;
    logic          last;
  } csd_cmd_t;
  localparam csd_cmd_t ZERO_CMD = '{b_i: '0, b_j: '0, one_term: 1'b1, b_sign: 1'b0,
                                    pair_neg: 1'b0, zero: 1'b1, last: 1'b1};
  // 01 -> +1 (2'b01), 11 -> -1 (2'b11), even -> 0
  function automatic digit_t naf_digit(input logic [1:0] x);
    return x[0] ? {x[1], 1'b1} : 2'b00;
  endfunction
endpackage

// File: rtl/csd_term_encoder_if.sv
// csd_term_encoder_if: weight input and two-term command output handshakes
interface csd_term_encoder_if #(parameter int N = 4);
  localparam int W = 2**N - 1;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_w;
  logic         out_vld;
  logic         out_rdy;
  logic [N-1:0] b_i;
  logic [N-1:0] b_j;
  logic         one_term;
  logic         b_sign;
  logic         pair_neg;
  logic         zero;
  logic         last;
  modport master (output in_vld, in_w, out_rdy,
                  input in_rdy, out_vld, b_i, b_j, one_term, b_sign, pair_neg, zero, last);
  modport slave (input in_vld, in_w, out_rdy,
                 output in_rdy, out_vld, b_i, b_j, one_term, b_sign, pair_neg, zero, last);
endinterface

// File: rtl/csd_cmd_pack.sv
// csd_cmd_pack: pairs the held digit with the current one and decides when a command is ready
module csd_cmd_pack
  import csd_pkg::*;
(
  input  logic          held_v,
  input  digit_t        held_d,
  input  logic [CN-1:0] held_idx,
  input  digit_t        d,
  input  logic [CN-1:0] idx,
  input  logic          x_zero,
  output logic          load,
  output csd_cmd_t      cmd,
  output logic          nheld_v,
  output digit_t        nheld_d,
  output logic [CN-1:0] nheld_idx
);
  logic nz, pair, keep;
  always_comb begin
    nz = d != 2'b00;
    pair = nz && held_v;
    keep = held_v || nz;
    nheld_d = nz && !held_v ? d : held_d;
    nheld_idx = nz && !held_v ? idx : held_idx;
    // a lone digit left when x runs out becomes a one-term command
    load = pair || (x_zero && keep);
    nheld_v = keep && !pair && !x_zero;
    cmd = '0;
    cmd.b_i = pair ? idx : nheld_idx;
    cmd.b_j = pair ? held_idx : '0;
    cmd.one_term = !pair;
    cmd.b_sign = pair && (held_d != d);
    cmd.pair_neg = pair ? d[1] : nheld_d[1];
    cmd.last = x_zero;
  end
endmodule

// File: rtl/csd_term_encoder.sv
// csd_term_encoder: recodes a weight into NAF one digit per cycle and emits two-term commands
module csd_term_encoder
  import csd_pkg::*;
#(
  parameter int N = CN
) (
  input logic               clk,
  input logic               rst,
  csd_term_encoder_if.slave bus
);
  localparam int W = 2**N - 1;
  state_t   state, state_n;
  logic [W:0] x, x_n;
  logic [N-1:0] idx, held_idx, nheld_idx;
  logic     held_v, nheld_v, load;
  digit_t   held_d, nheld_d, d;
  csd_cmd_t cmd, pk;
  assign d = naf_digit(x[1:0]);
  assign x_n = (x - {{(W-1){d[1]}}, d}) >> 1;
  csd_cmd_pack u_pack (
    .held_v(held_v), .held_d(held_d), .held_idx(held_idx), .d(d), .idx(idx),
    .x_zero(x_n == '0), .load(load), .cmd(pk),
    .nheld_v(nheld_v), .nheld_d(nheld_d), .nheld_idx(nheld_idx)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_vld) state_n = bus.in_w == '0 ? EMIT : SCAN;
      SCAN:    if (load) state_n = EMIT;
      EMIT:    if (bus.out_rdy) state_n = cmd.last ? IDLE : SCAN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      idx <= '0;
      held_v <= 1'b0;
      held_d <= '0;
      held_idx <= '0;
      cmd <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_vld) begin
        x <= {1'b0, bus.in_w};
        idx <= '0;
        held_v <= 1'b0;
        if (bus.in_w == '0) cmd <= ZERO_CMD;
      end else if (state == SCAN) begin
        x <= x_n;
        idx <= idx + 1'b1;
        held_v <= nheld_v;
        held_d <= nheld_d;
        held_idx <= nheld_idx;
        if (load) cmd <= pk;
      end
    end
  end
  assign bus.in_rdy = state == IDLE;
  assign bus.out_vld = state == EMIT;
  assign bus.b_i = cmd.b_i;
  assign bus.b_j = cmd.b_j;
  assign bus.one_term = cmd.one_term;
  assign bus.b_sign = cmd.b_sign;
  assign bus.pair_neg = cmd.pair_neg;
  assign bus.zero = cmd.zero;
  assign bus.last = cmd.last;
endmodule

// File: tb/tb_csd_term_encoder.sv
// tb_csd_term_encoder: random and directed weights checked against an arithmetic NAF model
module tb_csd_term_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  csd_term_encoder_if #(.N(4)) bus ();
  csd_term_encoder #(.N(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {int bi; int bj; bit ot; bit bs; bit pn; bit z; bit l;} ecmd_t;
  ecmd_t exp_q[$];
  int exp_lat;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] enc(input ecmd_t c);
    logic [3:0] bi, bj;
    bi = c.bi[3:0];
    bj = c.bj[3:0];
    return {bi, bj, c.ot, c.bs, c.pn, c.z, c.l};
  endfunction

  function automatic logic [12:0] dut_cmd();
    return {bus.b_i, bus.b_j, bus.one_term, bus.b_sign, bus.pair_neg, bus.zero, bus.last};
  endfunction

  function automatic longint cmd_val();
    longint v;
    v = longint'(1) << bus.b_i;
    if (!bus.one_term) v = bus.b_sign ? v - (longint'(1) << bus.b_j) : v + (longint'(1) << bus.b_j);
    if (bus.pair_neg) v = -v;
    return bus.zero ? 0 : v;
  endfunction

  // NAF digits by plain arithmetic, then consecutive nonzero digits paired low-first
  task automatic model(input int w);
    int v, k, d;
    int di[$];
    int dd[$];
    ecmd_t c;
    exp_q.delete();
    v = w;
    k = 0;
    while (v != 0) begin
      if (v % 2 != 0) begin
        d = 2 - (v % 4);
        di.push_back(k);
        dd.push_back(d);
        v = (v - d) / 2;
      end else v = v / 2;
      k++;
    end
    if (w == 0) begin
      c = '{bi: 0, bj: 0, ot: 1, bs: 0, pn: 0, z: 1, l: 1};
      exp_q.push_back(c);
      exp_lat = 1;
      return;
    end
    for (int i = 0; i < di.size(); i += 2) begin
      if (i + 1 < di.size())
        c = '{bi: di[i+1], bj: di[i], ot: 0, bs: dd[i] != dd[i+1], pn: dd[i+1] < 0, z: 0, l: i + 2 >= di.size()};
      else
        c = '{bi: di[i], bj: 0, ot: 1, bs: 0, pn: dd[i] < 0, z: 0, l: 1};
      exp_q.push_back(c);
    end
    exp_lat = (di.size() >= 2 ? di[1] : di[0]) + 2;
  endtask

  task automatic run(input int w, input int stall, input int stop);
    int lat, t;
    longint acc;
    logic [14:0] wv;
    model(w);
    t = 0;
    while (!bus.in_rdy && t < 50) begin step(); t++; end
    chk("in_rdy_idle", bus.in_rdy, 1);
    wv = w[14:0];
    bus.in_vld = 1'b1;
    bus.in_w = wv;
    step();
    bus.in_vld = 1'b0;
    lat = 1;
    acc = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      t = 0;
      while (!bus.out_vld && t < 40) begin step(); lat++; t++; end
      chk("out_vld", bus.out_vld, 1);
      if (!bus.out_vld) return;
      if (i == 0) chk("latency", lat, exp_lat);
      chk("in_rdy_busy", bus.in_rdy, 0);
      chk("cmd", dut_cmd(), enc(exp_q[i]));
      for (int s = 0; s < stall; s++) begin
        bus.in_vld = 1'b1;
        bus.in_w = 15'($urandom);
        step();
        bus.in_vld = 1'b0;
        chk("stall_vld", bus.out_vld, 1);
        chk("stall_cmd", dut_cmd(), enc(exp_q[i]));
      end
      acc += cmd_val();
      bus.out_rdy = 1'b1;
      step();
      bus.out_rdy = 1'b0;
      if (i + 1 == stop) return;
    end
    chk("recon", acc, w);
    chk("done_vld", bus.out_vld, 0);
    chk("done_rdy", bus.in_rdy, 1);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1 chk("rst_async_vld", bus.out_vld, 0);
    #2 rst = 1'b0;
    step();
    chk("rst_rdy", bus.in_rdy, 1);
    chk("rst_cmd", dut_cmd(), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_quiet", bus.out_vld, 0);
    end
  endtask

  initial begin
    int t;
    bus.in_vld = 1'b0;
    bus.in_w = '0;
    bus.out_rdy = 1'b0;
    #12;
    chk("reset_vld", bus.out_vld, 0);
    chk("reset_cmd", dut_cmd(), 0);
    rst = 1'b0;
    step();
    chk("reset_rdy", bus.in_rdy, 1);
    run(0, 0, -1);
    run(7, 0, -1);
    run(11, 3, -1);
    run(32'h1555, 0, -1);
    run(32'h7FFF, 1, -1);
    run(32'h1555, 0, 1);
    reset_pulse();
    run(8, 0, -1);
    run(32'h1555, 0, 1);
    t = 0;
    while (!bus.out_vld && t < 40) begin step(); t++; end
    chk("second_cmd_vld", bus.out_vld, 1);
    reset_pulse();
    run(32'h4000, 0, -1);
    run(1, 2, -1);
    for (int i = 0; i < 60; i++) run(int'($urandom_range(0, 32767)), int'($urandom_range(0, 2)), -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
